// File: rtl/event_sequencer_if.sv
// Configuration write port of the event sequencer.
// The master drives one register write per cycle.
interface event_sequencer_if #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 32
) ();
    logic              cfg_we;
    logic [ADDR_W-1:0] cfg_addr;
    logic [DATA_W-1:0] cfg_wdata;

    modport master (output cfg_we, cfg_addr, cfg_wdata);
    modport slave  (input  cfg_we, cfg_addr, cfg_wdata);
endinterface

// File: rtl/event_sequencer.sv
// Programmable frame-counter sequencer.
// Produces per-channel strobes and enable windows from runtime-written compare registers.
module event_sequencer #(
    parameter int unsigned           CNT_WIDTH  = 32,
    parameter int unsigned           NUM_CH     = 4,
    parameter logic [CNT_WIDTH-1:0]  PERIOD_DEF = CNT_WIDTH'(1000000000),
    parameter int unsigned           ADDR_W     = 5
) (
    input  logic                 clk,
    input  logic                 arst,
    event_sequencer_if.slave     cfg,
    input  logic                 start,
    input  logic                 stop,
    output logic [NUM_CH-1:0]    pulse,
    output logic [NUM_CH-1:0]    level,
    output logic [CNT_WIDTH-1:0] cnt,
    output logic                 wrap,
    output logic                 busy
);
    typedef enum logic {StIdle, StRun} state_e;

    state_e                state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0]  period_q, period_d;
    logic                  mode_q, mode_d;
    logic [CNT_WIDTH-1:0]  pulse_at_q [NUM_CH];
    logic [CNT_WIDTH-1:0]  pulse_at_d [NUM_CH];
    logic [CNT_WIDTH-1:0]  on_at_q [NUM_CH];
    logic [CNT_WIDTH-1:0]  on_at_d [NUM_CH];
    logic [CNT_WIDTH-1:0]  off_at_q [NUM_CH];
    logic [CNT_WIDTH-1:0]  off_at_d [NUM_CH];
    logic [NUM_CH-1:0]     pulse_en_q, pulse_en_d;
    logic [NUM_CH-1:0]     level_en_q, level_en_d;
    logic [NUM_CH-1:0]     pulse_q, pulse_d;
    logic [NUM_CH-1:0]     level_q, level_d;
    logic                  wrap_q, wrap_d;

    logic [CNT_WIDTH-1:0]  period_eff;
    logic                  frame_end;

    always_comb begin
        period_d   = period_q;
        mode_d     = mode_q;
        pulse_at_d = pulse_at_q;
        on_at_d    = on_at_q;
        off_at_d   = off_at_q;
        pulse_en_d = pulse_en_q;
        level_en_d = level_en_q;
        if (cfg.cfg_we) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (cfg.cfg_addr == ADDR_W'(4 * c))     pulse_at_d[c] = cfg.cfg_wdata;
                if (cfg.cfg_addr == ADDR_W'(4 * c + 1)) on_at_d[c]    = cfg.cfg_wdata;
                if (cfg.cfg_addr == ADDR_W'(4 * c + 2)) off_at_d[c]   = cfg.cfg_wdata;
                if (cfg.cfg_addr == ADDR_W'(4 * c + 3)) begin
                    pulse_en_d[c] = cfg.cfg_wdata[0];
                    level_en_d[c] = cfg.cfg_wdata[1];
                end
            end
            if (cfg.cfg_addr == ADDR_W'(4 * NUM_CH))     period_d = cfg.cfg_wdata;
            if (cfg.cfg_addr == ADDR_W'(4 * NUM_CH + 1)) mode_d   = cfg.cfg_wdata[0];
        end
    end

    // A PERIOD written below the running count lets the counter roll over at all-ones.
    assign period_eff = (period_q < CNT_WIDTH'(2)) ? CNT_WIDTH'(2) : period_q;
    assign frame_end  = (cnt_q == period_eff - CNT_WIDTH'(1)) || (cnt_q == '1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wrap_d  = 1'b0;
        pulse_d = '0;
        level_d = level_q;
        unique case (state_q)
            StIdle: begin
                cnt_d   = '0;
                level_d = '0;
                if (start && !stop) state_d = StRun;
            end
            StRun: begin
                if (stop) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    level_d = '0;
                end else begin
                    cnt_d  = frame_end ? '0 : cnt_q + CNT_WIDTH'(1);
                    wrap_d = frame_end;
                    for (int c = 0; c < NUM_CH; c++) begin
                        if (pulse_en_q[c] && cnt_q == pulse_at_q[c] && pulse_at_q[c] < period_eff)
                            pulse_d[c] = 1'b1;
                        // Clear has priority so ON_AT == OFF_AT never opens a window.
                        if (!level_en_q[c] ||
                            (cnt_q == off_at_q[c] && off_at_q[c] < period_eff))
                            level_d[c] = 1'b0;
                        else if (cnt_q == on_at_q[c] && on_at_q[c] < period_eff)
                            level_d[c] = 1'b1;
                    end
                    if (frame_end && !mode_q) begin
                        state_d = StIdle;
                        level_d = '0;
                        pulse_d = '0;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            period_q   <= PERIOD_DEF;
            mode_q     <= 1'b1;
            pulse_en_q <= '0;
            level_en_q <= '0;
            pulse_q    <= '0;
            level_q    <= '0;
            wrap_q     <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                pulse_at_q[c] <= '0;
                on_at_q[c]    <= '0;
                off_at_q[c]   <= '0;
            end
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            period_q   <= period_d;
            mode_q     <= mode_d;
            pulse_en_q <= pulse_en_d;
            level_en_q <= level_en_d;
            pulse_q    <= pulse_d;
            level_q    <= level_d;
            wrap_q     <= wrap_d;
            for (int c = 0; c < NUM_CH; c++) begin
                pulse_at_q[c] <= pulse_at_d[c];
                on_at_q[c]    <= on_at_d[c];
                off_at_q[c]   <= off_at_d[c];
            end
        end
    end

    assign pulse = pulse_q;
    assign level = level_q;
    assign cnt   = cnt_q;
    assign wrap  = wrap_q;
    assign busy  = (state_q == StRun);
endmodule

// File: tb/tb_event_sequencer.sv
// Scoreboard bench for event_sequencer: a per-cycle reference model queues expected outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_event_sequencer;
    localparam int unsigned CW  = 32;
    localparam int unsigned NCH = 4;
    localparam int unsigned AW  = 5;

    typedef struct packed {
        logic           busy;
        logic           wrap;
        logic [CW-1:0]  cnt;
        logic [NCH-1:0] level;
        logic [NCH-1:0] pulse;
    } obs_t;

    logic           clk = 1'b0;
    logic           arst = 1'b1;
    logic           start = 1'b0;
    logic           stop = 1'b0;
    logic [NCH-1:0] pulse;
    logic [NCH-1:0] level;
    logic [CW-1:0]  cnt;
    logic           wrap;
    logic           busy;

    int checks = 0;
    int failures = 0;
    obs_t exp_q[$];

    event_sequencer_if #(.ADDR_W(AW), .DATA_W(CW)) cfg_if ();

    event_sequencer #(
        .CNT_WIDTH (CW),
        .NUM_CH    (NCH),
        .PERIOD_DEF(32'd1000000000),
        .ADDR_W    (AW)
    ) dut (
        .clk  (clk),
        .arst (arst),
        .cfg  (cfg_if),
        .start(start),
        .stop (stop),
        .pulse(pulse),
        .level(level),
        .cnt  (cnt),
        .wrap (wrap),
        .busy (busy)
    );

    always #5 clk = ~clk;

    function automatic void check(string name, logic [63:0] got, logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
        end
    endfunction

    // Reference model: abstract frame state, stepped once per clock edge.
    bit                m_run;
    int unsigned       m_cnt;
    int unsigned       m_period;
    bit                m_mode;
    int unsigned       m_pat [NCH];
    int unsigned       m_on [NCH];
    int unsigned       m_off [NCH];
    bit [NCH-1:0]      m_pen;
    bit [NCH-1:0]      m_len;
    bit [NCH-1:0]      m_level;

    function automatic void model_reset();
        m_run = 0; m_cnt = 0; m_period = 1000000000; m_mode = 1;
        m_pen = '0; m_len = '0; m_level = '0;
        for (int i = 0; i < NCH; i++) begin
            m_pat[i] = 0; m_on[i] = 0; m_off[i] = 0;
        end
    endfunction

    function automatic bit hit(int unsigned at, int unsigned frame_len);
        return (m_cnt == at) && (at < frame_len);
    endfunction

    function automatic void model_step();
        obs_t        e;
        int unsigned frame_len;
        bit          last;
        int unsigned a;
        frame_len = (m_period < 2) ? 2 : m_period;
        e = '0;
        if (!m_run) begin
            m_cnt = 0;
            m_level = '0;
            if (start && !stop) m_run = 1;
        end else if (stop) begin
            m_run = 0; m_cnt = 0; m_level = '0;
        end else begin
            last = (m_cnt == frame_len - 1) || (m_cnt == 32'hFFFF_FFFF);
            for (int i = 0; i < NCH; i++) begin
                e.pulse[i] = m_pen[i] && hit(m_pat[i], frame_len);
                if (!m_len[i] || hit(m_off[i], frame_len)) m_level[i] = 0;
                else if (hit(m_on[i], frame_len)) m_level[i] = 1;
            end
            e.wrap = last;
            m_cnt = last ? 0 : m_cnt + 1;
            if (last && !m_mode) begin
                m_run = 0; m_level = '0; e.pulse = '0;
            end
        end
        e.busy = m_run;
        e.cnt = m_cnt;
        e.level = m_level;
        if (cfg_if.cfg_we) begin
            a = int'(cfg_if.cfg_addr);
            if (a < 4 * NCH) begin
                case (a % 4)
                    0: m_pat[a / 4] = cfg_if.cfg_wdata;
                    1: m_on[a / 4] = cfg_if.cfg_wdata;
                    2: m_off[a / 4] = cfg_if.cfg_wdata;
                    default: begin
                        m_pen[a / 4] = cfg_if.cfg_wdata[0];
                        m_len[a / 4] = cfg_if.cfg_wdata[1];
                    end
                endcase
            end else if (a == 4 * NCH) begin
                m_period = cfg_if.cfg_wdata;
            end else if (a == 4 * NCH + 1) begin
                m_mode = cfg_if.cfg_wdata[0];
            end
        end
        exp_q.push_back(e);
    endfunction

    always @(posedge clk) begin
        if (arst) model_reset();
        else model_step();
    end

    // Monitor: one DUT observation per cycle against the oldest queued expectation.
    always @(negedge clk) begin
        obs_t got;
        obs_t want;
        if (!arst && exp_q.size() > 0) begin
            want = exp_q.pop_front();
            got = '{busy: busy, wrap: wrap, cnt: cnt, level: level, pulse: pulse};
            check("cycle_outputs", 64'(got), 64'(want));
        end
    end

    task automatic drive(input bit we, input int unsigned addr, input int unsigned data,
                         input bit st, input bit sp);
        @(negedge clk);
        cfg_if.cfg_we = we;
        cfg_if.cfg_addr = AW'(addr);
        cfg_if.cfg_wdata = data;
        start = st;
        stop = sp;
    endtask

    task automatic wr(input int unsigned addr, input int unsigned data);
        drive(1, addr, data, 0, 0);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(0, 0, 0, 0, 0);
    endtask

    task automatic check_quiet(string name);
        check({name, "_pulse"}, 64'(pulse), 64'(0));
        check({name, "_level"}, 64'(level), 64'(0));
        check({name, "_cnt"}, 64'(cnt), 64'(0));
        check({name, "_wrap_busy"}, 64'({wrap, busy}), 64'(0));
    endtask

    initial begin
        cfg_if.cfg_we = 1'b0;
        cfg_if.cfg_addr = '0;
        cfg_if.cfg_wdata = '0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        arst = 1'b0;
        #1 check_quiet("reset");

        // Default period: counts freely with no wrap.
        drive(0, 0, 0, 1, 0);
        idle(30);
        drive(0, 0, 0, 0, 1);
        // Short period of 10.
        wr(16, 10);
        drive(0, 0, 0, 1, 0);
        idle(35);
        drive(0, 0, 0, 0, 1);

        // ch0 strobe at 50 with period 100.
        wr(16, 100); wr(0, 50); wr(3, 1);
        drive(0, 0, 0, 1, 0);
        idle(210);
        drive(0, 0, 0, 0, 1);

        // ch1 window spanning the wrap.
        wr(5, 90); wr(6, 10); wr(7, 2); wr(17, 1);
        drive(0, 0, 0, 1, 0);
        idle(210);
        drive(0, 0, 0, 0, 1);

        // One-shot frame.
        wr(17, 0); wr(16, 20);
        drive(0, 0, 0, 1, 0);
        idle(40);

        // start+stop together at cnt 37.
        wr(17, 1); wr(16, 100);
        drive(0, 0, 0, 1, 0);
        idle(37);
        drive(0, 0, 0, 1, 1);
        idle(5);

        // Degenerate window and out-of-frame strobe, then async reset mid-run.
        wr(9, 5); wr(10, 5); wr(11, 2); wr(12, 150); wr(15, 1);
        drive(0, 0, 0, 1, 0);
        idle(250);
        @(posedge clk);
        #1 arst = 1'b1;
        exp_q.delete();
        #1 check_quiet("async_reset");
        cfg_if.cfg_we = 1'b0; start = 1'b0; stop = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        arst = 1'b0;
        #1 check_quiet("post_reset");
        drive(0, 0, 0, 1, 0);
        idle(60);
        drive(0, 0, 0, 0, 1);

        // Randomized traffic including unmapped addresses and tiny periods.
        wr(16, 25);
        for (int i = 0; i < 4000; i++) begin
            int unsigned r;
            r = $urandom_range(0, 99);
            if (r < 25)
                wr($urandom_range(0, 31),
                   ($urandom_range(0, 29) == 0) ? $urandom : $urandom_range(0, 40));
            else if (r < 30) drive(0, 0, 0, 1, 0);
            else if (r < 31) drive(0, 0, 0, $urandom_range(0, 1), 1);
            else drive(0, 0, 0, 0, 0);
        end
        idle(3);
        check("scoreboard_drain", 64'(exp_q.size() <= 1), 64'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
